// File: rtl/sram_cache_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_cache_controller_pkg
// Purpose  : Shared constants for the 2-way write-through data cache that sits
//            between the MEM stage and the SRAM controller: controller state
//            encoding, address field positions and line geometry.
// Ports    : (package, none)
// Revision : 1.0 - initial release
// ============================================================================
package sram_cache_controller_pkg;

  // Address field layout (byte address): [1:0] byte, [2] word select,
  // [8:3] set index, [18:9] tag.
  localparam int WSEL_BIT  = 2;
  localparam int IDX_LSB   = 3;
  localparam int IDX_W_DEF = 6;
  localparam int TAG_LSB   = 9;
  localparam int TAG_W_DEF = 10;

  // Line geometry: two 32-bit words per line.
  localparam int WORD_W = 32;
  localparam int LINE_W = 64;

  // Controller states.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL0 = 3'd1;
  localparam logic [2:0] ST_FILL1 = 3'd2;
  localparam logic [2:0] ST_WRITE = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

endpackage : sram_cache_controller_pkg
`default_nettype wire

// File: rtl/sram_cache_controller_cache_storage.sv
`default_nettype none
// ============================================================================
// Module   : sram_cache_controller_cache_storage
// Purpose  : Tag/valid/data arrays for two ways plus a per-set LRU bit.
//            Lookup is combinational; line fills, word updates and LRU
//            updates are written on the rising clock edge. Valid and LRU bits
//            clear asynchronously on reset; tag/data arrays are not reset.
// Ports    : clk, rst            - clock, async active-high reset
//            index, tag, word_sel - decoded request address fields
//            hit, hit_way         - lookup result
//            hit_word             - selected word of the hitting line
//            victim_way           - way a fill would replace
//            line_we, line_data   - write full line into victim_way
//            word_we, word_data   - update word_sel word of hit_way
//            lru_we, lru_val      - write LRU bit of the set (= LRU way)
// Revision : 1.0 - initial release
// ============================================================================
module sram_cache_controller_cache_storage
  import sram_cache_controller_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int TAG_W = 10,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  index,
  input  logic [TAG_W-1:0]  tag,
  input  logic              word_sel,
  output logic              hit,
  output logic              hit_way,
  output logic [WORD_W-1:0] hit_word,
  output logic              victim_way,
  input  logic              line_we,
  input  logic [LINE_W-1:0] line_data,
  input  logic              word_we,
  input  logic [WORD_W-1:0] word_data,
  input  logic              lru_we,
  input  logic              lru_val
);

  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [LINE_W-1:0] data_mem [2][SETS];
  logic [SETS-1:0]   valid    [2];
  logic [SETS-1:0]   lru;        // holds the least-recently-used way per set

  logic [1:0]        way_hit;
  logic [LINE_W-1:0] way_line [2];
  logic [LINE_W-1:0] sel_line;

  generate
    for (genvar w = 0; w < 2; w++) begin : g_way
      assign way_line[w] = data_mem[w][index];
      assign way_hit[w]  = valid[w][index] && (tag_mem[w][index] == tag);
    end
  endgenerate

  assign hit      = |way_hit;
  // A line is only ever resident in one way, so way1's hit bit names the way.
  assign hit_way  = way_hit[1];
  assign sel_line = hit_way ? way_line[1] : way_line[0];
  assign hit_word = word_sel ? sel_line[LINE_W-1:WORD_W] : sel_line[WORD_W-1:0];

  // Fill empty ways first (way0 before way1), otherwise evict the LRU way.
  assign victim_way = !valid[0][index] ? 1'b0 :
                      !valid[1][index] ? 1'b1 : lru[index];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid[0] <= '0;
      valid[1] <= '0;
      lru      <= '0;
    end else begin
      if (line_we) valid[victim_way][index] <= 1'b1;
      if (lru_we)  lru[index]               <= lru_val;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_mem[victim_way][index]  <= tag;
      data_mem[victim_way][index] <= line_data;
    end else if (word_we) begin
      if (word_sel) data_mem[hit_way][index][LINE_W-1:WORD_W] <= word_data;
      else          data_mem[hit_way][index][WORD_W-1:0]      <= word_data;
    end
  end

endmodule : sram_cache_controller_cache_storage
`default_nettype wire

// File: rtl/sram_cache_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_cache_controller
// Purpose  : 2-way set-associative, write-through, no-write-allocate data
//            cache between the MEM stage and the SRAM controller. Read hits
//            complete with no added cycles; read misses fetch a 64-bit line as
//            two 32-bit SRAM reads; stores are written through to SRAM and
//            update the cached word only on a hit. ready drives the pipeline
//            freeze (freeze = ~ready).
// Ports    : clk, rst                 - clock, async active-high reset
//            rd_en, wr_en             - MEM-stage load / store request
//            address, wdata           - byte address, store data
//            rdata, ready             - load data, request complete
//            sram_rd_en, sram_wr_en   - registered SRAM requests
//            sram_address, sram_wdata - registered SRAM address / write data
//            sram_rdata, sram_ready   - SRAM read data, completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module sram_cache_controller
  import sram_cache_controller_pkg::*;
#(
  parameter int SETS  = 64,
  parameter int TAG_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  input  logic        sram_ready
);

  localparam int IDX_W     = $clog2(SETS);
  localparam int TAG_LSB_L = IDX_LSB + IDX_W;

  logic [2:0]        state;
  logic [WORD_W-1:0] word0;

  logic              hit;
  logic              hit_way;
  logic              victim_way;
  logic [WORD_W-1:0] hit_word;
  logic              line_we;
  logic              word_we;
  logic              lru_we;
  logic              lru_val;
  logic              rd_req;
  logic              unused_addr_bits;

  // Simultaneous rd_en and wr_en is serviced as a store.
  assign rd_req           = rd_en & ~wr_en;
  assign unused_addr_bits = ^address[1:0];

  sram_cache_controller_cache_storage #(
    .SETS  (SETS),
    .TAG_W (TAG_W),
    .IDX_W (IDX_W)
  ) u_storage (
    .clk        (clk),
    .rst        (rst),
    .index      (address[IDX_LSB +: IDX_W]),
    .tag        (address[TAG_LSB_L +: TAG_W]),
    .word_sel   (address[WSEL_BIT]),
    .hit        (hit),
    .hit_way    (hit_way),
    .hit_word   (hit_word),
    .victim_way (victim_way),
    .line_we    (line_we),
    .line_data  ({sram_rdata, word0}),
    .word_we    (word_we),
    .word_data  (wdata),
    .lru_we     (lru_we),
    .lru_val    (lru_val)
  );

  // Handshake, storage write strobes and load data.
  always_comb begin
    ready   = 1'b0;
    rdata   = '0;
    line_we = 1'b0;
    word_we = 1'b0;
    lru_we  = 1'b0;
    lru_val = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = ~(wr_en | (rd_en & ~hit));
        if (hit) rdata = hit_word;
        if (rd_req && hit) begin
          lru_we  = 1'b1;
          lru_val = ~hit_way;
        end
      end
      ST_FILL1: begin
        if (sram_ready && sram_rd_en) begin
          line_we = 1'b1;
          lru_we  = 1'b1;
          lru_val = ~victim_way;
        end
      end
      ST_WRITE: begin
        // No-write-allocate: only a resident line is touched.
        if (sram_ready && sram_wr_en && hit) begin
          word_we = 1'b1;
          lru_we  = 1'b1;
          lru_val = ~hit_way;
        end
      end
      ST_RESP: begin
        // The filled line is already resident here, so the lookup supplies it.
        ready = 1'b1;
        if (hit) rdata = hit_word;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      sram_rd_en   <= 1'b0;
      sram_wr_en   <= 1'b0;
      sram_address <= '0;
      sram_wdata   <= '0;
      word0        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_en) begin
            state        <= ST_WRITE;
            sram_wr_en   <= 1'b1;
            sram_address <= {address[31:2], 2'b00};
            sram_wdata   <= wdata;
          end else if (rd_en && !hit) begin
            state        <= ST_FILL0;
            sram_rd_en   <= 1'b1;
            sram_address <= {address[31:3], 3'b000};
          end
        end
        ST_FILL0: begin
          if (sram_ready && sram_rd_en) begin
            word0        <= sram_rdata;
            sram_rd_en   <= 1'b0;
            sram_address <= {address[31:3], 3'b100};
            state        <= ST_FILL1;
          end
        end
        ST_FILL1: begin
          // The enable is low for the first FILL1 cycle (dropped after the
          // first word completed); raise it again to request the second word.
          if (sram_ready && sram_rd_en) begin
            sram_rd_en <= 1'b0;
            state      <= ST_RESP;
          end else begin
            sram_rd_en <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (sram_ready && sram_wr_en) begin
            sram_wr_en <= 1'b0;
            state      <= ST_RESP;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : sram_cache_controller
`default_nettype wire
